// File: rtl/vga_scan_out_pkg.sv
// Shared VGA timing macros and the types used by the scan-out block.
// The macros keep the board-wide defaults in one place; the package carries the types.
`ifndef VGA_SCAN_OUT_DEFINES
`define VGA_SCAN_OUT_DEFINES
`define VGA_WIDTH   640
`define VGA_HEIGHT  480
`define VGA_H_FP    16
`define VGA_H_SYNC  96
`define VGA_H_BP    48
`define VGA_V_FP    10
`define VGA_V_SYNC  2
`define VGA_V_BP    33
`define VGA_H_TOTAL (`VGA_WIDTH + `VGA_H_FP + `VGA_H_SYNC + `VGA_H_BP)
`define VGA_V_TOTAL (`VGA_HEIGHT + `VGA_V_FP + `VGA_V_SYNC + `VGA_V_BP)
`define VGA_BLACK   16'h0000
`define VGA_WHITE   16'hFFFF
`endif

package vga_scan_out_pkg;

    localparam int unsigned CNT_W = 10;
    localparam logic [15:0] BLACK = `VGA_BLACK;

    typedef logic [CNT_W-1:0] cnt_t;

    // Internal timing bits are active-high; polarity is applied only at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_t;

    function automatic logic in_window(cnt_t v, int unsigned lo, int unsigned len);
        return (v >= cnt_t'(lo)) && (v < cnt_t'(lo + len));
    endfunction

endpackage

// File: rtl/vga_scan_if.sv
// Bundle between the raster generator, the page renderers and the VGA DAC pins.
// Coordinates flow out to the renderers, pix_data returns PIX_LAT cycles later.
interface vga_scan_if;
    import vga_scan_out_pkg::*;

    cnt_t        screen_x;
    cnt_t        screen_y;
    logic        screen_valid;
    logic        frame_start;
    logic [15:0] pix_data;
    logic [15:0] vga_rgb;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;

    modport master (
        output screen_x, screen_y, screen_valid, frame_start,
        input  pix_data,
        output vga_rgb, vga_hs, vga_vs, vga_de
    );

    modport slave (
        input  screen_x, screen_y, screen_valid, frame_start,
        output pix_data,
        input  vga_rgb, vga_hs, vga_vs, vga_de
    );
endinterface

// File: rtl/vga_scan_out_sync_delay.sv
// Shift register with synchronous clear that matches sync/blank timing to
// the renderers' pixel latency; DEPTH=0 degenerates to a wire.
module vga_sync_delay #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic unused_clk_clr;
            assign unused_clk_clr = clk ^ clr;
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            always_ff @(posedge clk) begin
                if (clr) begin
                    for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_out.sv
// Raster scan generator: drives coordinates to the page renderers and emits
// timed RGB565 plus hsync/vsync, with sync delayed to match pixel latency.
module vga_scan_out
    import vga_scan_out_pkg::*;
#(
    parameter int unsigned H_ACTIVE = `VGA_WIDTH,
    parameter int unsigned H_FP     = `VGA_H_FP,
    parameter int unsigned H_SYNC   = `VGA_H_SYNC,
    parameter int unsigned H_BP     = `VGA_H_BP,
    parameter int unsigned V_ACTIVE = `VGA_HEIGHT,
    parameter int unsigned V_FP     = `VGA_V_FP,
    parameter int unsigned V_SYNC   = `VGA_V_SYNC,
    parameter int unsigned V_BP     = `VGA_V_BP,
    parameter int unsigned PIX_LAT  = 1,
    parameter logic        SYNC_ACT = 1'b0
) (
    input logic       vga_clk,
    input logic       sys_rst,
    vga_scan_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    cnt_t  h_cnt;
    cnt_t  v_cnt;
    logic  h_last;
    logic  v_last;
    logic  active;
    sync_t raw;
    sync_t dly;

    assign h_last = (h_cnt == cnt_t'(H_TOTAL - 1));
    assign v_last = (v_cnt == cnt_t'(V_TOTAL - 1));

    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // Coordinates are quiet while reset is held so renderers never see a stale position.
    assign active = !sys_rst && (h_cnt < cnt_t'(H_ACTIVE)) && (v_cnt < cnt_t'(V_ACTIVE));

    assign bus.screen_valid = active;
    assign bus.screen_x     = active ? h_cnt : '0;
    assign bus.screen_y     = active ? v_cnt : '0;
    assign bus.frame_start  = !sys_rst && (h_cnt == '0) && (v_cnt == '0);

    always_comb begin
        raw    = '0;
        raw.hs = in_window(h_cnt, H_ACTIVE + H_FP, H_SYNC);
        raw.vs = in_window(v_cnt, V_ACTIVE + V_FP, V_SYNC);
        raw.de = active;
    end

    vga_sync_delay #(
        .DEPTH (PIX_LAT),
        .WIDTH ($bits(sync_t))
    ) u_sync_delay (
        .clk (vga_clk),
        .clr (sys_rst),
        .d   (raw),
        .q   (dly)
    );

    // One output register aligns the delayed timing with the sampled pixel.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            bus.vga_rgb <= BLACK;
            bus.vga_de  <= 1'b0;
            bus.vga_hs  <= !SYNC_ACT;
            bus.vga_vs  <= !SYNC_ACT;
        end else begin
            bus.vga_rgb <= dly.de ? bus.pix_data : BLACK;
            bus.vga_de  <= dly.de;
            bus.vga_hs  <= dly.hs ? SYNC_ACT : !SYNC_ACT;
            bus.vga_vs  <= dly.vs ? SYNC_ACT : !SYNC_ACT;
        end
    end

endmodule
